// File: rtl/lfsr_checker_if.sv
// lfsr_checker_if: seed/start control, serial input and result bundle for the LFSR checker.
// Latency: none (wires only).
// Backpressure: none; the checker takes one bit per cycle while in_valid is high.
interface lfsr_checker_if #(
    parameter int LFSR_WD = 8
);
    logic [LFSR_WD-1:0] seed;
    logic               start;
    logic               in_bit;
    logic               in_valid;
    logic               ready;
    logic               done;
    logic               pass;
    logic               fail;
    logic               timeout;
    logic [LFSR_WD-1:0] expected;
    logic [LFSR_WD-1:0] captured;
    logic [7:0]         err_count;

    // Stimulus side: drives seed, start and the serial stream.
    modport master (
        output seed, start, in_bit, in_valid,
        input  ready, done, pass, fail, timeout, expected, captured, err_count
    );

    // Checker side.
    modport slave (
        input  seed, start, in_bit, in_valid,
        output ready, done, pass, fail, timeout, expected, captured, err_count
    );
endinterface

// File: rtl/lfsr_checker.sv
// lfsr_checker: rebuilds the generator's LFSR word from a seed and compares it with the serial stream.
// Latency: ready N_SHIFTS cycles after start; done one cycle after the edge that takes the last bit.
// Backpressure: none; one bit consumed per cycle with in_valid high in RECV, gaps allowed.
// Optional macro LFSR_CHECKER_TIMEOUT_EN: fail the run after TIMEOUT consecutive idle cycles in RECV.
module lfsr_checker #(
    parameter int                 LFSR_WD  = 8,
    parameter logic [LFSR_WD-1:0] TAPS     = 8'hB8,
    parameter int                 N_SHIFTS = 10,
    parameter int                 TIMEOUT  = 32
) (
    input  logic          clk,
    input  logic          rst,
    lfsr_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        RECV = 2'd2,
        CMP  = 2'd3
    } state_t;

    localparam int CNT_WD = (N_SHIFTS > 1) ? $clog2(N_SHIFTS + 1) : 1;
    localparam int IDX_WD = (LFSR_WD > 1) ? $clog2(LFSR_WD) : 1;

    // Index of the final model step; GEN is never entered when N_SHIFTS is 0.
    localparam logic [CNT_WD-1:0] LAST_SHIFT = (N_SHIFTS > 0) ? CNT_WD'(N_SHIFTS - 1) : '0;
    localparam logic [IDX_WD-1:0] LAST_IDX   = IDX_WD'(LFSR_WD - 1);

    state_t              state_q;
    state_t              state_d;
    logic [LFSR_WD-1:0]  model_q;
    logic [LFSR_WD-1:0]  expected_q;
    logic [LFSR_WD-1:0]  captured_q;
    logic [CNT_WD-1:0]   shift_cnt_q;
    logic [IDX_WD-1:0]   bit_idx_q;
    logic                pass_q;
    logic                fail_q;
    logic                timeout_q;
    logic [7:0]          err_count_q;

`ifdef LFSR_CHECKER_TIMEOUT_EN
    localparam int                 IDLE_WD   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDLE_WD-1:0] LAST_IDLE = (TIMEOUT > 0) ? IDLE_WD'(TIMEOUT - 1) : '0;

    logic [IDLE_WD-1:0]  idle_cnt_q;
    logic                tmo_hit_q;
`endif

    // One Fibonacci step: XOR of tapped bits enters at the MSB, state shifts toward the LSB.
    function automatic logic [LFSR_WD-1:0] lfsr_step(input logic [LFSR_WD-1:0] s);
        logic fb;
        fb = ^(s & TAPS);
        return {fb, s[LFSR_WD-1:1]};
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start overrides every state and restarts the run.
    always_comb begin
        state_d = state_q;
        if (bus.start) begin
            state_d = (N_SHIFTS == 0) ? RECV : GEN;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                GEN: begin
                    if (shift_cnt_q == LAST_SHIFT) begin
                        state_d = RECV;
                    end
                end
                RECV: begin
                    if (bus.in_valid) begin
                        if (bit_idx_q == LAST_IDX) begin
                            state_d = CMP;
                        end
`ifdef LFSR_CHECKER_TIMEOUT_EN
                    end else if (idle_cnt_q == LAST_IDLE) begin
                        state_d = CMP;
`endif
                    end
                end
                CMP:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Model, deserializer, sticky results and error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            model_q     <= '0;
            expected_q  <= '0;
            captured_q  <= '0;
            shift_cnt_q <= '0;
            bit_idx_q   <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_count_q <= '0;
`ifdef LFSR_CHECKER_TIMEOUT_EN
            idle_cnt_q  <= '0;
            tmo_hit_q   <= 1'b0;
`endif
        end else if (bus.start) begin
            model_q     <= bus.seed;
            shift_cnt_q <= '0;
            bit_idx_q   <= '0;
            captured_q  <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            // With no shifts the seed itself is the expected word.
            if (N_SHIFTS == 0) begin
                expected_q <= bus.seed;
            end
`ifdef LFSR_CHECKER_TIMEOUT_EN
            idle_cnt_q  <= '0;
            tmo_hit_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                GEN: begin
                    model_q     <= lfsr_step(model_q);
                    shift_cnt_q <= shift_cnt_q + 1'b1;
                    if (shift_cnt_q == LAST_SHIFT) begin
                        expected_q <= lfsr_step(model_q);
                    end
                end
                RECV: begin
                    if (bus.in_valid) begin
                        captured_q[bit_idx_q] <= bus.in_bit;
                        bit_idx_q             <= bit_idx_q + 1'b1;
`ifdef LFSR_CHECKER_TIMEOUT_EN
                        idle_cnt_q            <= '0;
                    end else if (idle_cnt_q == LAST_IDLE) begin
                        tmo_hit_q  <= 1'b1;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
`endif
                    end
                end
                CMP: begin
`ifdef LFSR_CHECKER_TIMEOUT_EN
                    if (tmo_hit_q) begin
                        fail_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        if (err_count_q != 8'hFF) begin
                            err_count_q <= err_count_q + 8'd1;
                        end
                    end else
`endif
                    if (captured_q == expected_q) begin
                        pass_q <= 1'b1;
                    end else begin
                        fail_q <= 1'b1;
                        if (err_count_q != 8'hFF) begin
                            err_count_q <= err_count_q + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A start landing in CMP aborts the run, so it also suppresses that cycle's done.
    assign bus.ready     = (state_q == RECV);
    assign bus.done      = (state_q == CMP) && !bus.start;
    assign bus.pass      = pass_q;
    assign bus.fail      = fail_q;
    assign bus.timeout   = timeout_q;
    assign bus.expected  = expected_q;
    assign bus.captured  = captured_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed bench for lfsr_checker with N_SHIFTS=10 and N_SHIFTS=0 instances.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
// Builds with or without LFSR_CHECKER_TIMEOUT_EN; the timeout scenario follows the macro.
module tb_lfsr_checker;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    lfsr_checker_if #(.LFSR_WD(8)) bus_a ();
    lfsr_checker_if #(.LFSR_WD(8)) bus_z ();

    lfsr_checker #(.LFSR_WD(8), .TAPS(8'hB8), .N_SHIFTS(10), .TIMEOUT(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    lfsr_checker #(.LFSR_WD(8), .TAPS(8'hB8), .N_SHIFTS(0), .TIMEOUT(32)) dut_z (
        .clk (clk),
        .rst (rst),
        .bus (bus_z)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a run on the N_SHIFTS=10 instance and check ready rises exactly 10 edges later.
    task automatic start_a(input logic [7:0] s);
        bus_a.seed  = s;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        repeat (9) tick();
        n_cmp++; if (bus_a.ready !== 1'b0) begin n_err++; $display("FAIL ready_early: got %b want 0", bus_a.ready); end
        tick();
        n_cmp++; if (bus_a.ready !== 1'b1) begin n_err++; $display("FAIL ready_rise: got %b want 1", bus_a.ready); end
    endtask

    // Send 8 bits LSB first; returns in the cycle after the edge that takes the last bit.
    task automatic feed_a(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            bus_a.in_valid = 1'b1;
            bus_a.in_bit   = w[i];
            tick();
        end
        bus_a.in_valid = 1'b0;
        bus_a.in_bit   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (bus_a.ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", bus_a.ready); end
        n_cmp++; if (bus_a.done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", bus_a.done); end
        n_cmp++; if (bus_a.pass !== 1'b0) begin n_err++; $display("FAIL rst_pass: got %b want 0", bus_a.pass); end
        n_cmp++; if (bus_a.fail !== 1'b0) begin n_err++; $display("FAIL rst_fail: got %b want 0", bus_a.fail); end
        n_cmp++; if (bus_a.timeout !== 1'b0) begin n_err++; $display("FAIL rst_timeout: got %b want 0", bus_a.timeout); end
        n_cmp++; if (bus_a.expected !== 8'h00) begin n_err++; $display("FAIL rst_expected: got %h want 00", bus_a.expected); end
        n_cmp++; if (bus_a.captured !== 8'h00) begin n_err++; $display("FAIL rst_captured: got %h want 00", bus_a.captured); end
        n_cmp++; if (bus_a.err_count !== 8'h00) begin n_err++; $display("FAIL rst_err_count: got %h want 00", bus_a.err_count); end
        n_cmp++; if (bus_z.ready !== 1'b0) begin n_err++; $display("FAIL rst_z_ready: got %b want 0", bus_z.ready); end
    endtask

    // Seed 0x93 after 10 steps of taps 0xB8 gives 0x86 (93,49,A4,52,A9,D4,6A,35,1A,0D,86).
    task automatic test_pass();
        start_a(8'h93);
        n_cmp++; if (bus_a.expected !== 8'h86) begin n_err++; $display("FAIL pass_expected: got %h want 86", bus_a.expected); end
        feed_a(8'h86);
        n_cmp++; if (bus_a.done !== 1'b1) begin n_err++; $display("FAIL pass_done: got %b want 1", bus_a.done); end
        n_cmp++; if (bus_a.captured !== 8'h86) begin n_err++; $display("FAIL pass_captured: got %h want 86", bus_a.captured); end
        tick();
        n_cmp++; if (bus_a.done !== 1'b0) begin n_err++; $display("FAIL pass_done_single: got %b want 0", bus_a.done); end
        n_cmp++; if (bus_a.pass !== 1'b1) begin n_err++; $display("FAIL pass_pass: got %b want 1", bus_a.pass); end
        n_cmp++; if (bus_a.fail !== 1'b0) begin n_err++; $display("FAIL pass_fail: got %b want 0", bus_a.fail); end
        n_cmp++; if (bus_a.err_count !== 8'd0) begin n_err++; $display("FAIL pass_err_count: got %0d want 0", bus_a.err_count); end
        repeat (3) tick();
        n_cmp++; if (bus_a.pass !== 1'b1) begin n_err++; $display("FAIL pass_sticky: got %b want 1", bus_a.pass); end
    endtask

    task automatic test_fail();
        start_a(8'h93);
        n_cmp++; if (bus_a.pass !== 1'b0) begin n_err++; $display("FAIL start_clears_pass: got %b want 0", bus_a.pass); end
        feed_a(8'h87);
        n_cmp++; if (bus_a.done !== 1'b1) begin n_err++; $display("FAIL fail_done: got %b want 1", bus_a.done); end
        tick();
        n_cmp++; if (bus_a.fail !== 1'b1) begin n_err++; $display("FAIL fail_fail: got %b want 1", bus_a.fail); end
        n_cmp++; if (bus_a.pass !== 1'b0) begin n_err++; $display("FAIL fail_pass: got %b want 0", bus_a.pass); end
        n_cmp++; if (bus_a.err_count !== 8'd1) begin n_err++; $display("FAIL fail_err_count: got %0d want 1", bus_a.err_count); end
    endtask

    task automatic test_abort();
        // Abort in RECV after 4 bits.
        start_a(8'h93);
        for (int i = 0; i < 4; i++) begin
            bus_a.in_valid = 1'b1;
            bus_a.in_bit   = 1'b1;
            tick();
        end
        bus_a.in_valid = 1'b0;
        start_a(8'h93);
        n_cmp++; if (bus_a.err_count !== 8'd1) begin n_err++; $display("FAIL abort_recv_err: got %0d want 1", bus_a.err_count); end
        // Abort in CMP: a wrong word reaches compare, start arrives in the done cycle.
        feed_a(8'h00);
        bus_a.seed  = 8'h93;
        bus_a.start = 1'b1;
        #1;
        n_cmp++; if (bus_a.done !== 1'b0) begin n_err++; $display("FAIL abort_cmp_done: got %b want 0", bus_a.done); end
        tick();
        bus_a.start = 1'b0;
        n_cmp++; if (bus_a.fail !== 1'b0) begin n_err++; $display("FAIL abort_cmp_fail: got %b want 0", bus_a.fail); end
        n_cmp++; if (bus_a.err_count !== 8'd1) begin n_err++; $display("FAIL abort_cmp_err: got %0d want 1", bus_a.err_count); end
        repeat (10) tick();
        feed_a(8'h86);
        n_cmp++; if (bus_a.done !== 1'b1) begin n_err++; $display("FAIL abort_rerun_done: got %b want 1", bus_a.done); end
        tick();
        n_cmp++; if (bus_a.pass !== 1'b1) begin n_err++; $display("FAIL abort_rerun_pass: got %b want 1", bus_a.pass); end
        n_cmp++; if (bus_a.err_count !== 8'd1) begin n_err++; $display("FAIL abort_rerun_err: got %0d want 1", bus_a.err_count); end
    endtask

    // N_SHIFTS=0 instance, seed 0, bits separated by idle cycles.
    task automatic test_zero_seed();
        bus_z.seed  = 8'h00;
        bus_z.start = 1'b1;
        tick();
        bus_z.start = 1'b0;
        n_cmp++; if (bus_z.ready !== 1'b1) begin n_err++; $display("FAIL zero_ready: got %b want 1", bus_z.ready); end
        for (int i = 0; i < 8; i++) begin
            bus_z.in_valid = 1'b1;
            bus_z.in_bit   = 1'b0;
            tick();
            bus_z.in_valid = 1'b0;
            if (i < 7) tick();
        end
        n_cmp++; if (bus_z.done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b want 1", bus_z.done); end
        tick();
        n_cmp++; if (bus_z.pass !== 1'b1) begin n_err++; $display("FAIL zero_pass: got %b want 1", bus_z.pass); end
        n_cmp++; if (bus_z.captured !== 8'h00) begin n_err++; $display("FAIL zero_captured: got %h want 00", bus_z.captured); end
        n_cmp++; if (bus_z.expected !== 8'h00) begin n_err++; $display("FAIL zero_expected: got %h want 00", bus_z.expected); end
    endtask

    // err_count is 1 here; 300 more failing runs must saturate it at 255.
    task automatic test_saturate();
        for (int r = 0; r < 300; r++) begin
            bus_a.seed  = 8'h93;
            bus_a.start = 1'b1;
            tick();
            bus_a.start = 1'b0;
            repeat (10) tick();
            feed_a(8'h87);
            tick();
            if (r == 252) begin
                n_cmp++; if (bus_a.err_count !== 8'd254) begin n_err++; $display("FAIL sat_254: got %0d want 254", bus_a.err_count); end
            end
        end
        n_cmp++; if (bus_a.err_count !== 8'd255) begin n_err++; $display("FAIL sat_255: got %0d want 255", bus_a.err_count); end
        n_cmp++; if (bus_a.fail !== 1'b1) begin n_err++; $display("FAIL sat_fail: got %b want 1", bus_a.fail); end
    endtask

    task automatic test_rst_mid_gen();
        bus_a.seed  = 8'h93;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (bus_a.fail !== 1'b0) begin n_err++; $display("FAIL rstgen_fail: got %b want 0", bus_a.fail); end
        n_cmp++; if (bus_a.err_count !== 8'd0) begin n_err++; $display("FAIL rstgen_err: got %0d want 0", bus_a.err_count); end
        n_cmp++; if (bus_a.expected !== 8'h00) begin n_err++; $display("FAIL rstgen_expected: got %h want 00", bus_a.expected); end
        n_cmp++; if (bus_z.pass !== 1'b0) begin n_err++; $display("FAIL rstgen_z_pass: got %b want 0", bus_z.pass); end
        for (int i = 0; i < 12; i++) begin
            bus_a.in_valid = 1'b1;
            bus_a.in_bit   = 1'b1;
            tick();
        end
        bus_a.in_valid = 1'b0;
        n_cmp++; if (bus_a.ready !== 1'b0) begin n_err++; $display("FAIL rstgen_ready: got %b want 0", bus_a.ready); end
        n_cmp++; if (bus_a.captured !== 8'h00) begin n_err++; $display("FAIL rstgen_captured: got %h want 00", bus_a.captured); end
        n_cmp++; if (bus_a.done !== 1'b0) begin n_err++; $display("FAIL rstgen_done: got %b want 0", bus_a.done); end
    endtask

    task automatic test_timeout();
        start_a(8'h93);
        for (int i = 0; i < 3; i++) begin
            bus_a.in_valid = 1'b1;
            bus_a.in_bit   = 1'b0;
            tick();
        end
        bus_a.in_valid = 1'b0;
        repeat (31) tick();
        n_cmp++; if (bus_a.done !== 1'b0) begin n_err++; $display("FAIL tmo_done_early: got %b want 0", bus_a.done); end
        tick();
`ifdef LFSR_CHECKER_TIMEOUT_EN
        n_cmp++; if (bus_a.done !== 1'b1) begin n_err++; $display("FAIL tmo_done: got %b want 1", bus_a.done); end
        tick();
        n_cmp++; if (bus_a.fail !== 1'b1) begin n_err++; $display("FAIL tmo_fail: got %b want 1", bus_a.fail); end
        n_cmp++; if (bus_a.timeout !== 1'b1) begin n_err++; $display("FAIL tmo_timeout: got %b want 1", bus_a.timeout); end
        n_cmp++; if (bus_a.err_count !== 8'd1) begin n_err++; $display("FAIL tmo_err: got %0d want 1", bus_a.err_count); end
`else
        n_cmp++; if (bus_a.done !== 1'b0) begin n_err++; $display("FAIL tmo_no_done: got %b want 0", bus_a.done); end
        repeat (20) tick();
        n_cmp++; if (bus_a.done !== 1'b0) begin n_err++; $display("FAIL tmo_no_done_late: got %b want 0", bus_a.done); end
        n_cmp++; if (bus_a.timeout !== 1'b0) begin n_err++; $display("FAIL tmo_flag: got %b want 0", bus_a.timeout); end
        n_cmp++; if (bus_a.ready !== 1'b1) begin n_err++; $display("FAIL tmo_still_ready: got %b want 1", bus_a.ready); end
        n_cmp++; if (bus_a.err_count !== 8'd0) begin n_err++; $display("FAIL tmo_err: got %0d want 0", bus_a.err_count); end
`endif
    endtask

    initial begin
        bus_a.seed = 8'h00; bus_a.start = 1'b0; bus_a.in_bit = 1'b0; bus_a.in_valid = 1'b0;
        bus_z.seed = 8'h00; bus_z.start = 1'b0; bus_z.in_bit = 1'b0; bus_z.in_valid = 1'b0;
        tick();
        test_reset();
        test_pass();
        test_fail();
        test_abort();
        test_zero_seed();
        test_saturate();
        test_rst_mid_gen();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side partner of the serial LFSR generator. Loads the same seed and runs an internal LFSR model for the same number of shifts to form the expected word.
- Deserializes the generator's serial output (LSB first, qualified by valid) and compares it with the expected word.
- Reports pass/fail per run and keeps a saturating error count. Sits beside the LFSR as a self-check block for bring-up and BIST.

Parameters:
LFSR_WD, 8, width of the LFSR state, seed and captured word
TAPS, 8'hB8, feedback tap mask (bit i set = state[i] feeds the XOR)
N_SHIFTS, 10, number of LFSR steps the model runs before capture; 0 is legal
TIMEOUT, 32, idle cycles allowed in RECV between bits (used only with the optional feature)

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  reset, synchronous, active-high
seed  input  LFSR_WD  seed for the model; sampled only on a start cycle
start  input  1  single-cycle pulse that begins a run; accepted in any state
in_bit  input  1  serial data from the generator's out
in_valid  input  1  in_bit qualifier; one bit is consumed per clock while high
ready  output  1  high while in RECV, waiting for serial bits
done  output  1  one-cycle pulse when the comparison completes
pass  output  1  sticky result: expected word equals captured word
fail  output  1  sticky result: mismatch or timeout
timeout  output  1  sticky: the run ended by timeout
expected  output  LFSR_WD  model state after N_SHIFTS steps
captured  output  LFSR_WD  deserialized word
err_count  output  8  count of failed runs, saturates at 255

Behaviour:
- Reset (rst=1 at a clock edge) forces state IDLE and sets every output to 0: ready, done, pass, fail, timeout, expected, captured, err_count. rst has priority over start.
- LFSR step: fb = XOR-reduce(state & TAPS); next = {fb, state[LFSR_WD-1:1]}. Shift is toward the LSB and fb enters at the MSB. The model must match the generator bit for bit.
- FSM states: IDLE, GEN, RECV, CMP.
  - IDLE: in_bit and in_valid are ignored.
  - start (any state, including mid-run): model <= seed, shift count <= 0, bit index <= 0, captured <= 0, and pass, fail, timeout, done all cleared. Next state is GEN, or RECV when N_SHIFTS=0.
  - GEN: one model step per cycle. After the N_SHIFTS-th step, expected holds the final model value and the FSM goes to RECV. in_valid is ignored in GEN.
  - RECV: ready=1. On each edge with in_valid=1, captured[bit index] <= in_bit and the index increments. After bit LFSR_WD-1 is taken, go to CMP. Gaps in in_valid are allowed.
  - CMP (one cycle): done=1. pass=1 if captured==expected, else fail=1 and err_count increments, holding at 255. Return to IDLE.
- Latency: with start accepted at edge k, ready rises after edge k+N_SHIFTS. done is asserted on the cycle after the edge that takes the last bit.
- pass, fail and timeout hold until the next start or rst. err_count clears only on rst.
- A start during RECV or CMP aborts the run: no done pulse and no err_count change for the aborted run.
- Seed 0 is legal: the model stays 0 and expects 0x00.

Optional Feature:
- Macro: LFSR_CHECKER_TIMEOUT_EN.
- Defined: a counter in RECV counts consecutive cycles with in_valid=0 and resets on each accepted bit. When it reaches TIMEOUT, the FSM goes to CMP with a forced fail and sets timeout=1. done pulses and err_count increments.
- Not defined: there is no counter, timeout is tied to 0, and RECV waits indefinitely.

Test Plan:
- Default parameters, seed 0x93, start, then after ready feed bits LSB first 0,1,1,0,0,0,0,1 -> expected=0x86, captured=0x86, done pulses once, pass=1, err_count=0.
- Same seed, feed the bits for 0x87 -> fail=1, pass=0, err_count=1. Repeat 300 failing runs -> err_count holds at 255.
- Seed 0x00, N_SHIFTS=0 -> ready one cycle after start. Feed 8 zeros with in_valid toggling every other cycle -> pass=1, captured=0x00.
- Assert start after 4 bits in RECV with seed 0x93 -> no done for the aborted run, err_count unchanged. A full new run passes with 0x86.
- Assert rst mid-GEN -> all outputs 0 on the next cycle and state IDLE. in_valid pulses afterwards are ignored.
- With LFSR_CHECKER_TIMEOUT_EN and TIMEOUT=32, stop after 3 bits -> after 32 idle cycles, done=1, fail=1, timeout=1, err_count increments. Without the macro, timeout stays 0 and no done occurs.
